// File: rtl/conv_sched_pkg.sv
// conv_sched_pkg: shared state encoding and elaboration-time helpers for the convolution scheduler
package conv_sched_pkg;

    typedef enum logic [2:0] {IDLE, LOAD_K, RUN, DRAIN, DONE} state_t;

    function automatic int out_dim(input int in_dim, input int k, input int stride);
        return (in_dim - k) / stride + 1;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; (1 << i) < v; i++) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/conv_issue_pipe.sv
// conv_issue_pipe: fixed-latency delay line carrying issued output positions to the result strobe
module conv_issue_pipe #(
    parameter int DEPTH = 3,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    output logic         out_valid,
    output logic [W-1:0] out_x,
    output logic [W-1:0] out_y,
    output logic         empty
);

    logic [DEPTH-1:0] v;
    logic [W-1:0]     xs [DEPTH];
    logic [W-1:0]     ys [DEPTH];

    // shift one stage per cycle; empty slots carry zero coordinates
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
            end
        end else begin
            v[0]  <= in_valid;
            xs[0] <= in_valid ? in_x : '0;
            ys[0] <= in_valid ? in_y : '0;
            for (int i = 1; i < DEPTH; i++) begin
                v[i]  <= v[i-1];
                xs[i] <= xs[i-1];
                ys[i] <= ys[i-1];
            end
        end
    end

    // empty means nothing remains behind the output stage, so the pipe is clear after this cycle
    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) empty = empty & ~v[i];
    end

    assign out_valid = v[DEPTH-1];
    assign out_x     = xs[DEPTH-1];
    assign out_y     = ys[DEPTH-1];

endmodule

// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler: walks the output grid of one conv layer and issues credited multiplier firings
module conv_window_scheduler
    import conv_sched_pkg::*;
#(
    parameter int IN_WIDTH     = 8,
    parameter int IN_HEIGHT    = 8,
    parameter int K_WIDTH      = 3,
    parameter int K_HEIGHT     = 3,
    parameter int STRIDE       = 1,
    parameter int PIPE_LATENCY = 3,
    parameter int CREDITS      = 16,
    parameter int COORD_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               kernel_load_req,
    input  logic               kernel_load_ack,
    output logic               win_req,
    output logic [COORD_W-1:0] win_x,
    output logic [COORD_W-1:0] win_y,
    input  logic               win_valid,
    output logic               mult_en,
    output logic               res_valid,
    output logic [COORD_W-1:0] res_x,
    output logic [COORD_W-1:0] res_y,
    input  logic               credit_return
);

    localparam int OUT_W = out_dim(IN_WIDTH, K_WIDTH, STRIDE);
    localparam int OUT_H = out_dim(IN_HEIGHT, K_HEIGHT, STRIDE);
    localparam int CW    = clog2(CREDITS + 1);

    state_t             state, nxt;
    logic [COORD_W-1:0] ox, oy;
    logic [CW-1:0]      cred_cnt;
    logic               issue, last_col, last_pos, pipe_empty;

    assign issue    = (state == RUN) && win_valid && (cred_cnt != '0);
    assign last_col = ox == COORD_W'(OUT_W - 1);
    assign last_pos = last_col && (oy == COORD_W'(OUT_H - 1));

    // state register
    always_ff @(posedge clk) state <= rst ? IDLE : nxt;

    // next-state: a layer ends once the final position issues and the pipe drains
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? LOAD_K : IDLE;
            LOAD_K:  nxt = kernel_load_ack ? RUN : LOAD_K;
            RUN:     nxt = (issue && last_pos) ? DRAIN : RUN;
            DRAIN:   nxt = pipe_empty ? DONE : DRAIN;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // state-decoded handshakes; window address is the output position scaled by stride
    always_comb begin
        busy            = (state == LOAD_K) || (state == RUN) || (state == DRAIN);
        done            = state == DONE;
        kernel_load_req = state == LOAD_K;
        win_req         = state == RUN;
        mult_en         = issue;
        win_x           = COORD_W'(ox * STRIDE);
        win_y           = COORD_W'(oy * STRIDE);
    end

    // raster walk over the output grid, returned to origin after the final position
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start) || (issue && last_pos)) begin
            ox <= '0;
            oy <= '0;
        end else if (issue) begin
            ox <= last_col ? '0 : ox + 1'b1;
            oy <= last_col ? oy + 1'b1 : oy;
        end
    end

    // downstream slot credits: spend on issue, refund on return, saturate at full
    always_ff @(posedge clk) begin
        if (rst)
            cred_cnt <= CW'(CREDITS);
        else if (issue && !credit_return)
            cred_cnt <= cred_cnt - 1'b1;
        else if (!issue && credit_return && cred_cnt != CW'(CREDITS))
            cred_cnt <= cred_cnt + 1'b1;
    end

    conv_issue_pipe #(
        .DEPTH (PIPE_LATENCY),
        .W     (COORD_W)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .in_x      (ox),
        .in_y      (oy),
        .out_valid (res_valid),
        .out_x     (res_x),
        .out_y     (res_y),
        .empty     (pipe_empty)
    );

endmodule

// File: tb/tb_conv_window_scheduler.sv
// tb_conv_window_scheduler: randomized handshakes against a position-list reference model
module tb_conv_window_scheduler;

    localparam int IW = 9, IH = 7, KW = 3, KH = 3, S = 2, L = 3, C = 4, CWD = 8;
    localparam int OW = (IW - KW) / S + 1;
    localparam int OH = (IH - KH) / S + 1;
    localparam int N  = OW * OH;

    logic clk = 0, rst = 1, start = 0, ack = 0, wv = 0, cr = 0;
    logic busy, done, klr, win_req, mult_en, res_valid;
    logic [CWD-1:0] win_x, win_y, res_x, res_y;

    conv_window_scheduler #(
        .IN_WIDTH(IW), .IN_HEIGHT(IH), .K_WIDTH(KW), .K_HEIGHT(KH), .STRIDE(S),
        .PIPE_LATENCY(L), .CREDITS(C), .COORD_W(CWD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .kernel_load_req(klr), .kernel_load_ack(ack), .win_req(win_req),
        .win_x(win_x), .win_y(win_y), .win_valid(wv), .mult_en(mult_en),
        .res_valid(res_valid), .res_x(res_x), .res_y(res_y), .credit_return(cr)
    );

    always #5 clk = ~clk;

    typedef struct {bit v; int x; int y;} ent_t;
    ent_t q[$];
    int total = 0, bad = 0;
    int ph, idx, cred, layers = 0, results = 0;
    bit did_rst = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mreset();
        ph = 0; idx = 0; cred = C;
        q.delete();
        repeat (L) q.push_back('{0, 0, 0});
    endtask

    initial begin
        int cr_pct, wv_pct, ex, ey;
        bit e_issue, anyv;
        mreset();
        cr_pct = 40; wv_pct = 100;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cyc % 250 == 0) begin
                cr_pct = (cyc / 250) % 4 == 1 ? 0 : (cyc / 250) % 4 == 2 ? 90 : 40;
                wv_pct = (cyc / 250) % 3 == 0 ? 100 : (cyc / 250) % 3 == 1 ? 50 : 80;
            end
            rst   = (cyc < 1) || ($urandom_range(0, 499) == 0);
            if (!did_rst && cyc > 1200 && ph == 2 && idx >= 4) begin
                rst = 1; did_rst = 1;
            end
            start = $urandom_range(0, 3) == 0;
            ack   = $urandom_range(0, 2) == 0;
            wv    = $urandom_range(0, 99) < wv_pct;
            cr    = $urandom_range(0, 99) < cr_pct;
            #1;
            e_issue = (ph == 2) && wv && (cred > 0);
            ex = (ph == 2) ? (idx % OW) * S : 0;
            ey = (ph == 2) ? (idx / OW) * S : 0;
            if (cyc >= 1) begin
                chk("busy", busy, ph >= 1 && ph <= 3);
                chk("done", done, ph == 4);
                chk("kernel_load_req", klr, ph == 1);
                chk("win_req", win_req, ph == 2);
                chk("win_x", win_x, ex);
                chk("win_y", win_y, ey);
                chk("mult_en", mult_en, e_issue);
                chk("res_valid", res_valid, q[0].v);
                chk("res_x", res_x, q[0].x);
                chk("res_y", res_y, q[0].y);
            end
            if (rst) begin
                mreset();
                continue;
            end
            if (q[0].v) results++;
            void'(q.pop_front());
            if (e_issue) q.push_back('{1, idx % OW, idx / OW});
            else q.push_back('{0, 0, 0});
            anyv = 0;
            foreach (q[i]) anyv |= q[i].v;
            if (e_issue && !cr) cred--;
            else if (!e_issue && cr && cred < C) cred++;
            case (ph)
                0: if (start) ph = 1;
                1: if (ack) ph = 2;
                2: if (e_issue) begin
                       idx++;
                       if (idx == N) begin ph = 3; idx = 0; end
                   end
                3: if (!anyv) ph = 4;
                default: begin ph = 0; layers++; end
            endcase
        end
        chk("layers_done", layers >= 3, 1);
        chk("results_seen", results >= 3 * N, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
